seq_radix4_mult: RTL and testbench

//  Sequential unsigned multiplier. It consumes the multiplier two bits per clock.

---
 rtl/seq_radix4_mult.sv | 146 ++++++++++++++
 tb/tb_seq_radix4_mult.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_radix4_mult.sv
// seq_radix4_mult
//   Iterative unsigned multiplier that retires two multiplier bits per clock.
//   Each 2-bit digit selects 0, 1x, 2x or 3x of the captured multiplicand. That
//   partial product is shifted by 2*digit_index and added into a full-width
//   accumulator, so the accumulator can never overflow. A start/busy/done
//   handshake fronts the datapath. With EARLY_TERM=1 the operation stops as soon
//   as the remaining multiplier bits are all zero.
//
// Ports
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset; aborts an in-flight operation
//   start_i  request, sampled only while idle
//   mcand_i  multiplicand, captured when start is accepted
//   mplr_i   multiplier, captured when start is accepted
//   busy_o   high while an operation is in flight
//   done_o   one-cycle pulse, prod_o valid
//   prod_o   product, held until the next completion
//
// State | meaning
//   IDLE | waiting for start; prod_o holds the last result
//   RUN  | consuming multiplier digits, one per clock
module seq_radix4_mult #(
  parameter int MCAND_W    = 8,
  parameter int MPLR_W     = 8,
  parameter int EARLY_TERM = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [MCAND_W-1:0]         mcand_i,
  input  logic [MPLR_W-1:0]          mplr_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [MCAND_W+MPLR_W-1:0]  prod_o
);

  localparam int PROD_W = MCAND_W + MPLR_W;
  localparam int N      = MPLR_W / 2;
  localparam int CNT_W  = $clog2(N) + 1;
  localparam bit ET     = (EARLY_TERM != 0);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [MCAND_W-1:0] mc_q, mc_d;
  logic [MPLR_W-1:0]  sr_q, sr_d;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PROD_W-1:0]  prod_q, prod_d;

  logic [MCAND_W+1:0] pp;
  logic [CNT_W:0]     shamt;
  logic [PROD_W-1:0]  acc_sum;
  logic               last;
  logic               early;

  // 3x is built as x + 2x; the two extra bits hold the carry.
  always_comb begin
    pp = '0;
    case (sr_q[1:0])
      2'd0: pp = '0;
      2'd1: pp = {2'b00, mc_q};
      2'd2: pp = {1'b0, mc_q, 1'b0};
      2'd3: pp = {2'b00, mc_q} + {1'b0, mc_q, 1'b0};
      default: pp = '0;
    endcase
  end

  assign shamt   = {cnt_q, 1'b0};
  assign acc_sum = acc_q + (PROD_W'(pp) << shamt);
  assign last    = (cnt_q == CNT_W'(N - 1));
  assign early   = ET && (sr_q == '0);

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mc_d    = mcand_i;
          sr_d    = mplr_i;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (early) begin
          // Remaining digits are all zero, so acc already holds the product.
          prod_d  = acc_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          acc_d = acc_sum;
          sr_d  = sr_q >> 2;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            prod_d  = acc_sum;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mc_q    <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign prod_o = prod_q;

endmodule

// File: tb/tb_seq_radix4_mult.sv
module tb_seq_radix4_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [7:0]  mcand = 8'h00;
  logic [7:0]  mplr  = 8'h00;
  logic        busy0, done0, busy1, done1;
  logic [15:0] prod0, prod1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_radix4_mult #(.MCAND_W(8), .MPLR_W(8), .EARLY_TERM(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .mcand_i(mcand), .mplr_i(mplr),
    .busy_o(busy0), .done_o(done0), .prod_o(prod0)
  );

  seq_radix4_mult #(.MCAND_W(8), .MPLR_W(8), .EARLY_TERM(1)) u_dut_et (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .mcand_i(mcand), .mplr_i(mplr),
    .busy_o(busy1), .done_o(done1), .prod_o(prod1)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          lat;
  } vec_t;

  vec_t vecs[12];
  vec_t et_vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference latency: D = 1 + index of highest non-zero digit (0 if none);
  // full-length runs finish after 4 edges, early ones after D+1.
  function automatic int ref_lat(input bit et, input int b);
    int d;
    if (!et) return 4;
    d = 0;
    for (int i = 0; i < 4; i++)
      if (((b / (4 ** i)) % 4) != 0) d = i + 1;
    return (d + 1 < 4) ? d + 1 : 4;
  endfunction

  // Launch one operation, wait for done, return latency (edges after the
  // accepting edge) and product. Also checks busy stays high until done and
  // that done lasts exactly one cycle.
  task automatic run_op(input bit et, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat);
    bit d;
    bit busy_ok;
    mcand = a;
    mplr  = b;
    if (et) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    mcand = 8'($urandom);
    mplr  = 8'($urandom);
    busy_ok = (et ? busy1 : busy0);
    lat = 0;
    d = 1'b0;
    while (!d && lat < 20) begin
      tick();
      lat++;
      d = et ? done1 : done0;
      if (!d && !(et ? busy1 : busy0)) busy_ok = 1'b0;
    end
    if (!d) check("done_timeout", 32'(d), 32'd1);
    p = et ? prod1 : prod0;
    check("busy_low_at_done", 32'(et ? busy1 : busy0), 32'd0);
    if (!busy_ok) check("busy_during_run", 32'(busy_ok), 32'd1);
    tick();
    check("done_one_cycle", 32'(et ? done1 : done0), 32'd0);
  endtask

  initial begin
    logic [15:0] p;
    int          lat;
    int          ndone;
    int          t1, t2;
    logic [15:0] p1, p2;
    logic [7:0]  ra, rb;

    vecs[0]  = '{8'hFF, 8'hFF, 16'hFE01, 4};
    vecs[1]  = '{8'hA5, 8'h3C, 16'h26AC, 4};
    vecs[2]  = '{8'h00, 8'h00, 16'h0000, 4};
    vecs[3]  = '{8'h01, 8'h01, 16'h0001, 4};
    vecs[4]  = '{8'hFF, 8'h00, 16'h0000, 4};
    vecs[5]  = '{8'h00, 8'hFF, 16'h0000, 4};
    vecs[6]  = '{8'h80, 8'h02, 16'h0100, 4};
    vecs[7]  = '{8'h7F, 8'h01, 16'h007F, 4};
    vecs[8]  = '{8'h12, 8'h34, 16'h03A8, 4};
    vecs[9]  = '{8'hFF, 8'h01, 16'h00FF, 4};
    vecs[10] = '{8'h01, 8'hFF, 16'h00FF, 4};
    vecs[11] = '{8'h55, 8'hAA, 16'h3872, 4};

    et_vecs[0] = '{8'h7F, 8'h00, 16'h0000, 1};
    et_vecs[1] = '{8'h7F, 8'h01, 16'h007F, 2};
    et_vecs[2] = '{8'h7F, 8'hC0, 16'h5F40, 4};
    et_vecs[3] = '{8'h03, 8'h04, 16'h000C, 3};
    et_vecs[4] = '{8'hFF, 8'h30, 16'h2FD0, 4};
    et_vecs[5] = '{8'hFF, 8'hFF, 16'hFE01, 4};

    // Reset state
    tick(); tick();
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_prod", 32'(prod0), 32'd0);
    check("rst_busy_et", 32'(busy1), 32'd0);
    check("rst_prod_et", 32'(prod1), 32'd0);
    rst = 1'b0;
    tick();

    // Directed table, EARLY_TERM=0
    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, p, lat);
      check($sformatf("vec%0d_prod", i), 32'(p), 32'(vecs[i].p));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Directed table, EARLY_TERM=1
    foreach (et_vecs[i]) begin
      run_op(1'b1, et_vecs[i].a, et_vecs[i].b, p, lat);
      check($sformatf("et%0d_prod", i), 32'(p), 32'(et_vecs[i].p));
      check($sformatf("et%0d_lat", i), 32'(lat), 32'(et_vecs[i].lat));
    end

    // Start while busy is ignored
    mcand = 8'hFF; mplr = 8'hFF; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 2) begin mcand = 8'h12; mplr = 8'h34; start0 = 1'b1; end
      if (i == 3) start0 = 1'b0;
      tick();
      if (done0) ndone++;
    end
    check("busy_start_ndone", 32'(ndone), 32'd1);
    check("busy_start_prod", 32'(prod0), 32'hFE01);

    // Reset on the second RUN cycle
    mcand = 8'hA5; mplr = 8'h3C; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_done", 32'(done0), 32'd0);
    check("midrst_prod", 32'(prod0), 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done0) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run_op(1'b0, 8'h12, 8'h34, p, lat);
    check("midrst_after_prod", 32'(p), 32'h03A8);

    // Back-to-back: start held through done
    mcand = 8'hFF; mplr = 8'hFF; start0 = 1'b1;
    tick();
    mcand = 8'h12; mplr = 8'h34;
    ndone = 0; t1 = 0; t2 = 0; p1 = '0; p2 = '0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (ndone == 1 && i == t1 + 1) start0 = 1'b0;
      if (done0) begin
        ndone++;
        if (ndone == 1) begin t1 = i; p1 = prod0; end
        else if (ndone == 2) begin t2 = i; p2 = prod0; end
      end
    end
    start0 = 1'b0;
    check("b2b_ndone", 32'(ndone), 32'd2);
    check("b2b_first_lat", 32'(t1), 32'd4);
    check("b2b_spacing", 32'(t2 - t1), 32'd5);
    check("b2b_prod1", 32'(p1), 32'hFE01);
    check("b2b_prod2", 32'(p2), 32'h03A8);

    // Randomized against the arithmetic reference
    for (int i = 0; i < 1200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(1'b0, ra, rb, p, lat);
      check("rand_prod", 32'(p), 32'(ra) * 32'(rb));
      check("rand_lat", 32'(lat), 32'(ref_lat(1'b0, int'(rb))));
    end
    for (int i = 0; i < 600; i++) begin
      ra = 8'($urandom);
      // bias towards short multipliers so early termination is exercised
      rb = 8'($urandom) >> $urandom_range(0, 8);
      run_op(1'b1, ra, rb, p, lat);
      check("rand_et_prod", 32'(p), 32'(ra) * 32'(rb));
      check("rand_et_lat", 32'(lat), 32'(ref_lat(1'b1, int'(rb))));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
